ps2_key_encoder: RTL and testbench
==================================

PS2_KEY_ENCODER -- requirements
Module: ps2_key_encoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 24000: idle clk_sys cycles after the last ps2_clk falling edge that abort a partial frame (1 ms at 24 MHz).
REQ-002 SHALL have parameter FILTER_LEN, default 8: consecutive equal samples needed to accept a ps2_clk level (used only when the filter is compiled in).
REQ-003 SHALL have port clk_sys, input, 1: single system clock; every flop is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1: raw PS/2 clock line, asynchronous to clk_sys.
REQ-006 SHALL have port ps2_data, input, 1: raw PS/2 data line, asynchronous to clk_sys.
REQ-007 SHALL have port ps2_key, output, 11: [10] event toggle, [9] pressed, [8] extended (E0), [7:0] scan code.
REQ-008 SHALL have port frame_err, output, 1: one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-009 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers before any other use.
REQ-010 SHALL sample synchronised ps2_data on each detected falling edge of synchronised or filtered ps2_clk.
REQ-011 SHALL use FSM states IDLE, DATA, PARITY, STOP: IDLE->DATA on a sampled 0 (start bit); a sampled 1 in IDLE is ignored; DATA->PARITY after the 8th bit (LSB first); PARITY->STOP on the next edge; STOP->IDLE on the next edge.
REQ-012 SHALL accept a frame only if the parity bit makes the 9-bit total odd and the stop bit is 1; otherwise it SHALL pulse frame_err, discard the byte and clear the pending release/extended flags.
REQ-013 SHALL abort any non-IDLE state to IDLE, pulse frame_err and clear the flags if TIMEOUT_CYC cycles pass with no falling edge; the counter is 16 bits and saturates.
REQ-014 SHALL, on an accepted byte E0, set the extended flag and emit nothing.
REQ-015 SHALL, on an accepted byte F0, set the release flag and emit nothing.
REQ-016 SHALL, on an accepted byte E1, discard the next 7 accepted bytes and emit nothing (Pause sequence); an error during the skip clears the skip count.
REQ-017 SHALL, on any other accepted byte, update ps2_key in the cycle after the stop-bit edge to {~ps2_key[10], ~release, extended, byte}, then clear both flags.
REQ-018 SHALL change ps2_key[10] exactly once per emitted event; bits [9:0] change only in the same cycle as the toggle.
REQ-019 SHALL keep consecutive prefixes cumulative (E0 F0 xx gives extended=1, pressed=0) and SHALL treat a repeated prefix as idempotent.
REQ-020 SHALL never emit for a byte whose frame timed out, even if the bits arrive later.

Reset
REQ-021 While reset_n=0: ps2_key=11'h000, frame_err=0, FSM=IDLE, flags, skip count, shift register and timeout counter cleared; synchronisers preset to 1 (idle bus).
REQ-022 Reset asserted mid-frame SHALL drop the partial frame with no frame_err pulse; decoding resumes at the next start bit after release.

Configuration
REQ-023 Macro PS2_KEY_FILTER_EN defined: ps2_clk SHALL be accepted only after FILTER_LEN equal consecutive samples, adding FILTER_LEN cycles of edge latency.
REQ-024 PS2_KEY_FILTER_EN undefined: the synchronised ps2_clk SHALL be used directly; FILTER_LEN is ignored.

Structure
REQ-025 A shared package ps2_pkg SHALL hold the FSM state enum, the prefix constants E0/F0/E1 and the ps2_key bit-index constants.
REQ-026 Sub-module ps2_clk_filter SHALL contain the synchroniser and optional filter and output a one-cycle falling-edge strobe.

Verification
REQ-027 Bench SHALL cover: frame 1C (A), parity 0, stop 1 -> ps2_key[9:0]=10'h21C, bit10 toggles once, frame_err=0.
REQ-028 Bench SHALL cover: bytes F0,1C -> one event with ps2_key[9:0]=10'h01C, no event for F0.
REQ-029 Bench SHALL cover: bytes E0,F0,75 -> ps2_key[9:0]=10'h175; then 75 alone -> 10'h275 (flags cleared).
REQ-030 Bench SHALL cover: frame 29 with wrong parity -> one frame_err pulse, ps2_key unchanged; next valid 29 -> 10'h229.
REQ-031 Bench SHALL cover: 4 data bits then a 30000-cycle gap -> frame_err at cycle TIMEOUT_CYC, FSM=IDLE; next valid 76 -> 10'h276.
REQ-032 Bench SHALL cover: E1,14,77,E1,F0,14,F0,77 -> no event; following 05 -> 10'h205; also reset_n pulsed mid-frame -> outputs 0 and no frame_err.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard decoder types and constants.
// Frame FSM states, scan-code prefixes, ps2_key bit positions.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_REL   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;

  localparam int KEY_TGL  = 10;
  localparam int KEY_PRS  = 9;
  localparam int KEY_EXT  = 8;
  localparam int KEY_CODE = 0;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line synchronisers and ps2_clk falling-edge strobe.
// Define PS2_KEY_FILTER_EN to add a FILTER_LEN-sample glitch filter.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall
);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] dat_sync_q, dat_sync_d;
  logic       lvl;
  logic       lvl_prev_q;

  // two-stage synchronisers, idle-high bus
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
  end

  // synchroniser flops
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
    end
  end

`ifdef PS2_KEY_FILTER_EN
  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // adopt a new level only after FILTER_LEN differing samples in a row
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1))
        filt_d = clk_sync_q[1];
      else
        cnt_d = cnt_q + 1'b1;
    end
  end

  // filter state
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = clk_sync_q[1];
`endif

  // previous clock level for edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) lvl_prev_q <= 1'b1;
    else          lvl_prev_q <= lvl;
  end

  assign fall   = lvl_prev_q & ~lvl;
  assign data_s = dat_sync_q[1];

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard frame receiver and scan-code event encoder.
// Optional ps2_clk glitch filter: define PS2_KEY_FILTER_EN.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 24000,
  parameter int FILTER_LEN  = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  logic data_s;
  logic fall;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .data_s  (data_s),
    .fall    (fall)
  );

  ps2_state_e  state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic [15:0] tmo_q, tmo_d;
  logic        ext_q, ext_d;
  logic        rel_q, rel_d;
  logic [2:0]  skip_q, skip_d;
  logic [10:0] key_q, key_d;
  logic        err_q, err_d;
  logic        frame_ok;

  assign frame_ok = (^{shift_q, par_q}) & data_s;

  // frame FSM, timeout watchdog and prefix decoding
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tmo_d   = tmo_q;
    ext_d   = ext_q;
    rel_d   = rel_q;
    skip_d  = skip_q;
    key_d   = key_q;
    err_d   = 1'b0;

    if (state_q == ST_IDLE || fall)
      tmo_d = '0;
    else if (tmo_q != 16'hFFFF)
      tmo_d = tmo_q + 16'd1;

    if (state_q != ST_IDLE && !fall &&
        tmo_q >= 16'(TIMEOUT_CYC - 1)) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
      skip_d  = '0;
    end else if (fall) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
        ST_DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!frame_ok) begin
            err_d  = 1'b1;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = '0;
          end else if (skip_q != '0) begin
            skip_d = skip_q - 3'd1;
          end else if (shift_q == PFX_EXT) begin
            ext_d = 1'b1;
          end else if (shift_q == PFX_REL) begin
            rel_d = 1'b1;
          end else if (shift_q == PFX_PAUSE) begin
            skip_d = PAUSE_SKIP;
          end else begin
            key_d = {~key_q[KEY_TGL], ~rel_q, ext_q, shift_q};
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // decoder state registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      skip_q  <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      ext_q   <= ext_d;
      rel_q   <= rel_d;
      skip_q  <= skip_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Scoreboard bench for ps2_key_encoder.
// Random and directed PS/2 frames against a byte-level model.
module tb_ps2_key_encoder;

  localparam int TMO  = 24000;
  localparam int HALF = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_key_encoder #(
    .TIMEOUT_CYC(TMO),
    .FILTER_LEN (8)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int err_cyc = -1;

  logic [9:0] exp_q[$];
  int         err_exp_q[$];

  bit       m_ext = 0;
  bit       m_rel = 0;
  int       m_skip = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // monitor: every key change or error pulse must match the scoreboard
  initial begin
    logic [10:0] prev;
    logic        tgl;
    logic [9:0]  e;
    int          tag;
    prev = '0;
    tgl  = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (!reset_n) begin
        prev = '0;
        tgl  = 1'b0;
        continue;
      end
      if (ps2_key != prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got %h want none", ps2_key);
        end else begin
          e   = exp_q.pop_front();
          tgl = ~tgl;
          if (ps2_key !== {tgl, e}) begin
            errors++;
            $display("FAIL event got %h want %h", ps2_key, {tgl, e});
          end
        end
        prev = ps2_key;
      end
      if (frame_err) begin
        checks++;
        err_cyc = cyc;
        if (err_exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_err got 1 want 0 at cyc %0d", cyc);
        end else begin
          tag = err_exp_q.pop_front();
        end
      end
    end
  end

  // byte-level model of the prefix rules
  task automatic model(input logic [7:0] b, input bit ok);
    if (!ok) begin
      err_exp_q.push_back(1);
      m_ext  = 0;
      m_rel  = 0;
      m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else begin
      exp_q.push_back({~m_rel, m_ext, b});
      m_ext = 0;
      m_rel = 0;
    end
  endtask

  task automatic ps2_bit(input logic v);
    @(negedge clk_sys);
    ps2_data = v;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit badp, input bit bads);
    model(b, !(badp || bads));
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ badp);
    ps2_bit(~bads);
    @(negedge clk_sys);
    ps2_data = 1'b1;
    repeat (4 * HALF) @(negedge clk_sys);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (ps2_key !== 11'h000) begin
      errors++;
      $display("FAIL reset_key got %h want 000", ps2_key);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b want 0", frame_err);
    end
    m_ext  = 0;
    m_rel  = 0;
    m_skip = 0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    reset_n  = 1'b1;
    repeat (4) @(negedge clk_sys);
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    int         d;

    do_reset();

    send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h75);
    send_frame(8'h29, 1'b1, 1'b0);
    send(8'h29);
    send_frame(8'h3A, 1'b0, 1'b1);

    // partial frame then silence
    model(8'h00, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    err_cyc = -1;
    repeat (30000) @(negedge clk_sys);
    d = err_cyc - last_fall;
    checks++;
    if (err_cyc < 0 || d < TMO || d > TMO + 5) begin
      errors++;
      $display("FAIL timeout_delay got %0d want %0d..%0d", d, TMO, TMO + 5);
    end
    send(8'h76);

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h05);

    repeat (20) @(negedge clk_sys);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    do_reset();
    send(8'h1C);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'h5A;
        default: b = 8'($urandom_range(0, 255));
      endcase
      r = $urandom_range(0, 9);
      send_frame(b, r == 0, r == 1);
    end
    send(8'h66);

    repeat (50) @(negedge clk_sys);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d want 0", exp_q.size());
    end
    checks++;
    if (err_exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_errs got %0d want 0", err_exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
